// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   MODE_ADD / MODE_SUB : encodings of the k mode input
//   lo_w()              : width of the low (stage-1) half of the adder
//   flags_t             : registered status flags presented at the output
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int unsigned lo_w(input int unsigned width);
        return width / 2;
    endfunction

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit adder slice with carry in and carry out.
// Ports:
//   a, b  [W-1:0]  addends
//   cin            carry in
//   sum   [W-1:0]  a + b + cin, truncated to W bits
//   cout           carry out of the slice
module addsub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage pipelined adder/subtractor with valid/ready handshake on both sides.
// Stage 1 adds the low half and registers its carry plus the high operand halves;
// stage 2 adds the high half and registers the result and status flags.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready operand handshake (a, b, k)
//   a, b [WIDTH-1:0]    operands
//   k                   mode: 0 = a+b, 1 = a-b
//   out_valid/out_ready result handshake
//   s [WIDTH-1:0]       result
//   cout, ovf           raw carry (1 = no borrow on subtract), signed overflow
//   zero, neg           s == 0, s[WIDTH-1]
// Build option: define ADDSUB_SAT_EN to clamp s to signed max/min on overflow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int LO_W = int'(lo_w(WIDTH));
    localparam int HI_W = WIDTH - LO_W;

    typedef struct packed {
        logic [LO_W-1:0] lo_sum;
        logic            lo_c;
        logic [HI_W-1:0] a_hi;
        logic [HI_W-1:0] bx_hi;
    } s1_t;

    logic             s1_valid;
    s1_t              s1_q;
    flags_t           flags_q;

    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] bx;
    logic [LO_W-1:0]  lo_sum;
    logic             lo_c;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_c;
    logic [WIDTH-1:0] raw_s;
    logic             raw_ovf;
    logic [WIDTH-1:0] res_s;

    // Ready propagates backwards combinationally so a full pipe can accept
    // and retire in the same cycle without inserting a bubble.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = !rst && s1_adv;

    assign bx = (k == MODE_SUB) ? ~b : b;

    addsub_slice #(.W(LO_W)) u_lo (
        .a    (a[LO_W-1:0]),
        .b    (bx[LO_W-1:0]),
        .cin  (k),
        .sum  (lo_sum),
        .cout (lo_c)
    );

    addsub_slice #(.W(HI_W)) u_hi (
        .a    (s1_q.a_hi),
        .b    (s1_q.bx_hi),
        .cin  (s1_q.lo_c),
        .sum  (hi_sum),
        .cout (hi_c)
    );

    always_comb begin
        raw_s   = {hi_sum, s1_q.lo_sum};
        raw_ovf = (s1_q.a_hi[HI_W-1] == s1_q.bx_hi[HI_W-1]) &&
                  (hi_sum[HI_W-1] != s1_q.a_hi[HI_W-1]);
`ifdef ADDSUB_SAT_EN
        // Overflow direction follows the common operand sign: both negative
        // clamps to signed min, both positive to signed max.
        if (raw_ovf) begin
            res_s = s1_q.a_hi[HI_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_s = raw_s;
        end
`else
        res_s = raw_s;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            flags_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= '{lo_sum: lo_sum, lo_c: lo_c,
                              a_hi: a[WIDTH-1:LO_W], bx_hi: bx[WIDTH-1:LO_W]};
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    s       <= res_s;
                    flags_q <= '{cout: hi_c, ovf: raw_ovf,
                                 zero: (res_s == '0), neg: res_s[WIDTH-1]};
                end
            end
        end
    end

    assign cout = flags_q.cout;
    assign ovf  = flags_q.ovf;
    assign zero = flags_q.zero;
    assign neg  = flags_q.neg;

endmodule
